phase_sequencer: RTL

Multi-cycle control unit for the 16-bit SIMPLE datapath (IR/AR/BR/DR/MDR, register file, ALU, PC). It steps each instruction through phases P1 fetch, P2 register read, P3 execute, P4 memory and P5 write-back. From the phase, IR fields, ALU flags and a memory-ready handshake it generates every register enable, mux select and ALU opcode. It sits beside the datapath in the top level, and the datapath's enable wires connect to its outputs.

---
 rtl/simple_ctrl_pkg.sv | 54 +++++
 rtl/branch_cond.sv | 28 ++
 rtl/phase_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/simple_ctrl_pkg.sv
// Shared encodings for the SIMPLE multi-cycle control unit: states, opcode fields,
// branch conditions and ALU opcodes.
package simple_ctrl_pkg;

   // Low five bits double as the one-hot phase output; HALT drives phase 0.
   typedef enum logic [5:0] {
      StP1   = 6'b000001,
      StP2   = 6'b000010,
      StP3   = 6'b000100,
      StP4   = 6'b001000,
      StP5   = 6'b010000,
      StHalt = 6'b100000
   } state_e;

   localparam logic [4:0] PhaseReset = 5'b00001;

   localparam logic [1:0] Op1Ld  = 2'b00;
   localparam logic [1:0] Op1St  = 2'b01;
   localparam logic [1:0] Op1Br  = 2'b10;
   localparam logic [1:0] Op1Alu = 2'b11;

   localparam logic [2:0] Op2Li  = 3'b000;
   localparam logic [2:0] Op2B   = 3'b100;
   localparam logic [2:0] Op2Bcc = 3'b111;

   localparam logic [3:0] Op3Add = 4'b0000;
   localparam logic [3:0] Op3Sub = 4'b0001;
   localparam logic [3:0] Op3And = 4'b0010;
   localparam logic [3:0] Op3Or  = 4'b0011;
   localparam logic [3:0] Op3Xor = 4'b0100;
   localparam logic [3:0] Op3Cmp = 4'b0101;
   localparam logic [3:0] Op3Mov = 4'b0110;
   localparam logic [3:0] Op3Sll = 4'b1000;
   localparam logic [3:0] Op3Slr = 4'b1001;
   localparam logic [3:0] Op3Srl = 4'b1010;
   localparam logic [3:0] Op3Sra = 4'b1011;
   localparam logic [3:0] Op3In  = 4'b1100;
   localparam logic [3:0] Op3Out = 4'b1101;
   localparam logic [3:0] Op3Hlt = 4'b1111;

   localparam logic [2:0] CondBe  = 3'b000;
   localparam logic [2:0] CondBlt = 3'b001;
   localparam logic [2:0] CondBle = 3'b010;
   localparam logic [2:0] CondBne = 3'b011;

   localparam logic [3:0] AluAdd = Op3Add;
   localparam logic [3:0] AluMov = Op3Mov;

   // ALU-class op3 codes that perform a real operation (HLT handled separately).
   function automatic logic op3_defined(input logic [3:0] op3);
      return !(op3 == 4'b0111 || op3 == 4'b1110 || op3 == Op3Hlt);
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-taken evaluation for B (unconditional) and the Bcc family from S/Z/V.
module branch_cond
   import simple_ctrl_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] op2,
   input  logic       S,
   input  logic       Z,
   input  logic       V,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      if (op2 == Op2B) begin
         taken = 1'b1;
      end else if (op2 == Op2Bcc) begin
         unique case (cond)
            CondBe:  taken = Z;
            CondBlt: taken = S ^ V;
            CondBle: taken = Z | (S ^ V);
            CondBne: taken = ~Z;
            default: taken = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase control unit for the SIMPLE datapath. Define PHASE_SKIP_EN to let
// non-memory instructions go straight from P3 to P5.
module phase_sequencer
   import simple_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ir,
   input  logic             S,
   input  logic             Z,
   input  logic             C,
   input  logic             V,
   input  logic             mem_rdy,
   input  logic             run,
   output logic [4:0]       phase,
   output logic             ir_e,
   output logic             pc_e,
   output logic             ar_e,
   output logic             br_e,
   output logic             dr_e,
   output logic             mr_e,
   output logic             alu_e,
   output logic             flag_e,
   output logic [3:0]       ALU_Cnt,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             addr_s,
   output logic             m1_s,
   output logic             m2_s,
   output logic             m3_s,
   output logic             m4_s,
   output logic             reg_read,
   output logic             reg_write,
   output logic             halted,
   output logic [WIDTH-1:0] pc_rst_val
);

   state_e state_q, state_d;

   logic [1:0] op1;
   logic [2:0] op2, cond;
   logic [3:0] op3;
   logic is_ld, is_st, is_mem, is_li, is_br, is_alu, is_hlt, valid;
   logic alu_wr, alu_flag, taken;
   logic unused_bits;

   assign op1  = ir[15:14];
   assign op2  = ir[13:11];
   assign cond = ir[10:8];
   assign op3  = ir[7:4];

   assign is_ld    = (op1 == Op1Ld);
   assign is_st    = (op1 == Op1St);
   assign is_mem   = is_ld | is_st;
   assign is_li    = (op1 == Op1Br) && (op2 == Op2Li);
   assign is_br    = (op1 == Op1Br) && (op2 == Op2B || op2 == Op2Bcc);
   assign is_alu   = (op1 == Op1Alu) && op3_defined(op3);
   assign is_hlt   = (op1 == Op1Alu) && (op3 == Op3Hlt);
   assign valid    = is_mem | is_li | is_br | is_alu;
   assign alu_wr   = is_alu && (op3 != Op3Cmp) && (op3 != Op3Out);
   assign alu_flag = is_alu && (op3 != Op3Out);

   assign pc_rst_val  = PC_RESET;
   assign unused_bits = ^{C, ir[3:0]};

   branch_cond u_branch_cond (
      .cond  (cond),
      .op2   (op2),
      .S     (S),
      .Z     (Z),
      .V     (V),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= StP1;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StP1: if (mem_rdy) state_d = StP2;
         StP2: state_d = StP3;
         StP3: begin
            if (is_hlt) begin
               state_d = StHalt;
            end else begin
`ifdef PHASE_SKIP_EN
               state_d = is_mem ? StP4 : StP5;
`else
               state_d = StP4;
`endif
            end
         end
         StP4:   if (!is_mem || mem_rdy) state_d = StP5;
         StP5:   state_d = StP1;
         StHalt: if (run) state_d = StP1;
         default: state_d = StP1;
      endcase
   end

   always_comb begin
      phase     = state_q[4:0];
      halted    = (state_q == StHalt);
      ir_e      = 1'b0;
      pc_e      = 1'b0;
      ar_e      = 1'b0;
      br_e      = 1'b0;
      dr_e      = 1'b0;
      mr_e      = 1'b0;
      alu_e     = 1'b0;
      flag_e    = 1'b0;
      ALU_Cnt   = 4'b0000;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr_s    = 1'b0;
      m1_s      = 1'b0;
      m2_s      = 1'b0;
      m3_s      = 1'b0;
      m4_s      = 1'b0;
      reg_read  = 1'b0;
      reg_write = 1'b0;
      // Reset masks the decode so an aborted instruction cannot strobe anything.
      if (rst) begin
         phase  = PhaseReset;
         halted = 1'b0;
      end else begin
         unique case (state_q)
            StP1: begin
               mem_rd = 1'b1;
               ir_e   = mem_rdy;
               pc_e   = mem_rdy;
            end
            StP2: begin
               if (valid) begin
                  reg_read = 1'b1;
                  ar_e     = 1'b1;
                  br_e     = 1'b1;
                  m2_s     = is_br | is_li;
                  m3_s     = is_br | is_li | is_mem;
               end
            end
            StP3: begin
               if (valid) begin
                  alu_e   = 1'b1;
                  dr_e    = 1'b1;
                  flag_e  = alu_flag;
                  ALU_Cnt = is_alu ? op3 : (is_li ? AluMov : AluAdd);
               end
            end
            StP4: begin
               if (is_ld) begin
                  mem_rd = 1'b1;
                  addr_s = 1'b1;
                  mr_e   = mem_rdy;
               end else if (is_st) begin
                  mem_wr = 1'b1;
                  addr_s = 1'b1;
               end
            end
            StP5: begin
               reg_write = is_ld | is_li | alu_wr;
               m4_s      = is_ld;
               pc_e      = is_br & taken;
               m1_s      = is_br & taken;
            end
            default: ;
         endcase
      end
   end

endmodule
